aes_stream_feeder: RTL and testbench
====================================

Name: aes_stream_feeder

Overview:
Streaming front/back end for the AES cipher core.
- Accepts 32-bit plaintext words on a valid/ready input and packs four words into a 128-bit block.
- Drives the core's ld/key/text_in, waits for done, captures text_out, and serialises the ciphertext as four 32-bit words on a valid/ready output.
- Sits directly upstream and downstream of the cipher core in the AES top level.
- One block in flight at a time.

Parameters:
- TIMEOUT_CYC, 32, max cycles in WAIT for core_done before error abort (>=16)
- CNT_W, 16, width of completed-block counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- key_in  in  128  cipher key to latch
- key_we  in  1  latch key_in into key register
- in_data  in  32  plaintext word; first word of a block = bits [127:96]
- in_valid  in  1  in_data valid
- in_ready  out  1  feeder accepts word this cycle
- out_data  out  32  ciphertext word; first word = bits [127:96]
- out_valid  out  1  out_data valid
- out_ready  in  1  sink accepts word
- core_ld  out  1  one-cycle load pulse to cipher core
- core_key  out  128  key register contents
- core_text_in  out  128  assembled plaintext block
- core_text_out  in  128  cipher result
- core_done  in  1  cipher done pulse
- busy  out  1  high in any state except COLLECT with word count 0
- err  out  1  sticky timeout flag, cleared only by rst
- key_rej  out  1  one-cycle pulse: key_we ignored because busy
- blk_cnt  out  CNT_W  completed blocks, wraps modulo 2^CNT_W

Behaviour:
Reset (async, rst=1): all outputs and registers are 0, including key register, text register, word count, blk_cnt, err, core_ld, out_valid and in_ready. State is COLLECT. First cycle after reset release: in_ready=1.

States:
- COLLECT
  - in_ready=1.
  - Handshake in_valid&in_ready writes in_data into slot wcnt (0..3) of the text register. Slot 0 = [127:96].
  - wcnt increments on each handshake.
  - On the handshake with wcnt=3: wcnt wraps to 0 and the next state is LOAD.
- LOAD
  - in_ready=0.
  - core_ld=1 for exactly this one cycle, with core_text_in and core_key stable.
  - Next state is WAIT. Timeout counter clears to 0.
- WAIT
  - core_done is sampled only in this state; core_done in any other state is ignored.
  - When core_done=1: capture core_text_out into the result register; next state is DRAIN.
  - Otherwise the timeout counter increments. When it reaches TIMEOUT_CYC-1 without done: set err, discard the block, return to COLLECT with wcnt=0, and do not increment blk_cnt.
- DRAIN
  - out_valid=1 and out_data = result slot ocnt.
  - Each out_valid&out_ready handshake increments ocnt.
  - out_data/out_valid hold stable while out_ready=0.
  - On the handshake with ocnt=3: ocnt resets to 0, blk_cnt increments, and next state is COLLECT. in_ready=1 in the following cycle (no combinational ready path).

Key handling:
- key_we while busy=0: key register <= key_in on the next edge.
- key_we while busy=1: ignored, key_rej pulses for one cycle.
- core_key is never altered mid-block.
- Simultaneous key_we and the first word handshake (busy=0 in that cycle): both take effect.

Throughput and latency:
- Minimum latency from the 4th input handshake to first out_valid = 2 cycles + core latency.
- Back-pressure on out_ready stalls indefinitely with no timeout.

Reset mid-operation: abort immediately; a partially collected or in-flight block is lost; err and blk_cnt are cleared.

Decomposition:
- Package aes_feeder_pkg:
  - typedef enum state_t {COLLECT, LOAD, WAIT, DRAIN}
  - typedef logic [127:0] blk_t
  - WORDS_PER_BLK = 4
  - word-slot index function (slot i = [127-32i -: 32])
- One natural sub-module: aes_word_packer. It holds the 128-bit register, writes a slot by index, and reads a slot by index. Instantiate it twice, once for plaintext packing and once for ciphertext unpacking.

Test Plan:
1. FIPS-197 vector:
   - Stimulus: key_we with key 000102030405060708090a0b0c0d0e0f, then words 00112233, 44556677, 8899aabb, ccddeeff.
   - Required response: out words 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a; blk_cnt=1; core_ld high exactly 1 cycle.
2. Input gaps and back-pressure:
   - Stimulus: in_valid toggled every other cycle; out_ready held 0 for 10 cycles after out_valid rises.
   - Required response: same ciphertext; out_data stable during the stall; in_ready=0 throughout WAIT/DRAIN.
3. Key rejection:
   - Stimulus: key_we during WAIT.
   - Required response: key_rej pulses for 1 cycle; core_key unchanged; result matches the old key. key_we in idle COLLECT takes effect for the next block.
4. Timeout:
   - Stimulus: stub core never asserts done, TIMEOUT_CYC=32.
   - Required response: err=1 by 32 cycles after LOAD; returns to COLLECT; blk_cnt=0; in_ready=1; the next block processes normally and err stays 1.
5. Reset mid-operation:
   - Stimulus: assert rst after 2 words, and again during DRAIN after 1 output word.
   - Required response: all outputs 0 asynchronously; after release a fresh 4-word block yields the correct full 4-word output.
6. Counter wrap:
   - Stimulus: CNT_W=2, 5 back-to-back blocks.
   - Required response: blk_cnt sequence 1, 2, 3, 0, 1; spurious core_done pulses in COLLECT/DRAIN are ignored.

Source files
------------

// File: rtl/aes_feeder_pkg.sv
// aes_feeder_pkg: shared types and helpers for the AES stream feeder.
// Block type, FSM states and 32-bit word-slot indexing.
package aes_feeder_pkg;

  typedef enum logic [1:0] {
    COLLECT,
    LOAD,
    WAIT,
    DRAIN
  } state_t;

  typedef logic [127:0] blk_t;

  localparam int WORDS_PER_BLK = 4;

  // slot i occupies [127-32i -: 32]; slot 0 is the first word on the wire
  function automatic logic [6:0] slot_msb(input logic [1:0] idx);
    return 7'd127 - {idx, 5'd0};
  endfunction

endpackage

// File: rtl/aes_word_packer.sv
// aes_word_packer: 128-bit register written and read one 32-bit slot at a time.
// Ports: clk, rst, i_wr_en/i_wr_idx/i_wr_data, i_ld_en/i_ld_data, i_rd_idx, o_rd_data, o_blk.
module aes_word_packer
  import aes_feeder_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_wr_en,
  input  logic [1:0]  i_wr_idx,
  input  logic [31:0] i_wr_data,
  input  logic        i_ld_en,
  input  blk_t        i_ld_data,
  input  logic [1:0]  i_rd_idx,
  output logic [31:0] o_rd_data,
  output blk_t        o_blk
);

  blk_t r_blk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_blk <= '0;
    end else if (i_ld_en) begin
      r_blk <= i_ld_data;
    end else if (i_wr_en) begin
      r_blk[slot_msb(i_wr_idx) -: 32] <= i_wr_data;
    end
  end

  assign o_rd_data = r_blk[slot_msb(i_rd_idx) -: 32];
  assign o_blk     = r_blk;

endmodule

// File: rtl/aes_stream_feeder.sv
// aes_stream_feeder: packs 4 plaintext words, runs the AES core, unpacks result.
// Ports: word in (valid/ready), word out (valid/ready), core ld/key/text/done, status.
module aes_stream_feeder
  import aes_feeder_pkg::*;
#(
  parameter int TIMEOUT_CYC = 32,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [127:0]     key_in,
  input  logic             key_we,
  input  logic [31:0]      in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             core_ld,
  output logic [127:0]     core_key,
  output logic [127:0]     core_text_in,
  input  logic [127:0]     core_text_out,
  input  logic             core_done,
  output logic             busy,
  output logic             err,
  output logic             key_rej,
  output logic [CNT_W-1:0] blk_cnt
);

  localparam int            TW     = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [1:0]    LAST_W = 2'(WORDS_PER_BLK - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [1:0]       r_wcnt;
  logic [1:0]       r_ocnt;
  logic [TW-1:0]    r_tcnt;
  logic [127:0]     r_key;
  logic             r_err;
  logic             r_key_rej;
  logic [CNT_W-1:0] r_blk_cnt;

  logic             w_busy;
  logic             w_in_hs;
  logic             w_out_hs;
  logic             w_done;
  logic             w_timeout;
  logic [TW-1:0]    w_tcnt_inc;
  logic [31:0]      w_txt_word;
  blk_t             w_res_blk;
  logic             w_unused;

  assign w_busy     = !(r_state == COLLECT && r_wcnt == 2'd0);
  assign w_in_hs    = in_valid && in_ready;
  assign w_out_hs   = out_valid && out_ready;
  assign w_done     = (r_state == WAIT) && core_done;
  assign w_tcnt_inc = r_tcnt + TW'(1);
  assign w_timeout  = (r_state == WAIT) && !core_done
                   && (w_tcnt_inc == T_LAST);
  assign w_unused   = ^{w_txt_word, w_res_blk};

  // ready is held low while reset is asserted even though state is COLLECT
  assign in_ready  = (r_state == COLLECT) && !rst;
  assign out_valid = (r_state == DRAIN);
  assign core_ld   = (r_state == LOAD);
  assign core_key  = r_key;
  assign busy      = w_busy;
  assign err       = r_err;
  assign key_rej   = r_key_rej;
  assign blk_cnt   = r_blk_cnt;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      COLLECT: if (w_in_hs && r_wcnt == LAST_W) w_state_nxt = LOAD;
      LOAD:    w_state_nxt = WAIT;
      WAIT: begin
        if (w_done)         w_state_nxt = DRAIN;
        else if (w_timeout) w_state_nxt = COLLECT;
      end
      DRAIN:   if (w_out_hs && r_ocnt == LAST_W) w_state_nxt = COLLECT;
      default: w_state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= COLLECT;
      r_wcnt    <= '0;
      r_ocnt    <= '0;
      r_tcnt    <= '0;
      r_key     <= '0;
      r_err     <= 1'b0;
      r_key_rej <= 1'b0;
      r_blk_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_in_hs)  r_wcnt <= r_wcnt + 2'd1;
      if (w_out_hs) r_ocnt <= r_ocnt + 2'd1;
      if (r_state == LOAD) begin
        r_tcnt <= '0;
      end else if (r_state == WAIT && !core_done) begin
        r_tcnt <= w_tcnt_inc;
      end
      if (w_timeout) r_err <= 1'b1;
      if (w_out_hs && r_ocnt == LAST_W) begin
        r_blk_cnt <= r_blk_cnt + CNT_W'(1);
      end
      r_key_rej <= key_we && w_busy;
      if (key_we && !w_busy) r_key <= key_in;
    end
  end

  aes_word_packer u_txt (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (w_in_hs),
    .i_wr_idx  (r_wcnt),
    .i_wr_data (in_data),
    .i_ld_en   (1'b0),
    .i_ld_data ('0),
    .i_rd_idx  (r_wcnt),
    .o_rd_data (w_txt_word),
    .o_blk     (core_text_in)
  );

  aes_word_packer u_res (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (1'b0),
    .i_wr_idx  (2'd0),
    .i_wr_data (32'd0),
    .i_ld_en   (w_done),
    .i_ld_data (core_text_out),
    .i_rd_idx  (r_ocnt),
    .o_rd_data (out_data),
    .o_blk     (w_res_blk)
  );

endmodule

// File: tb/tb_aes_stream_feeder.sv
// tb_aes_stream_feeder: directed bench with a stub cipher core.
// Stub returns known FIPS-197 ciphertexts for the two reference vectors.
module tb_aes_stream_feeder;

  localparam logic [127:0] FIPS_K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2     = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] P2     = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] C2     = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] JUNK   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] key_in = '0;
  logic         key_we = 1'b0;
  logic [31:0]  in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic         core_ld;
  logic [127:0] core_key;
  logic [127:0] core_text_in;
  logic [127:0] core_text_out;
  logic         core_done;
  logic         busy;
  logic         err;
  logic         key_rej;
  logic [1:0]   blk_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int ld_cycles = 0;
  int viol = 0;

  logic         stub_hang = 1'b0;
  logic         stub_busy;
  logic         stub_done;
  logic         spur_done = 1'b0;
  logic [127:0] stub_out;
  int           stub_cnt;

  always #5 clk = ~clk;

  aes_stream_feeder #(.TIMEOUT_CYC(32), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_we(key_we),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .core_ld(core_ld), .core_key(core_key), .core_text_in(core_text_in),
    .core_text_out(core_text_out), .core_done(core_done),
    .busy(busy), .err(err), .key_rej(key_rej), .blk_cnt(blk_cnt)
  );

  function automatic logic [127:0] cipher(input logic [127:0] t,
                                          input logic [127:0] k);
    if (t == FIPS_P && k == FIPS_K) return FIPS_C;
    if (t == P2 && k == K2) return C2;
    return t ^ k;
  endfunction

  // stub core: fixed 3-cycle latency after ld, optional hang
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      stub_busy <= 1'b0;
      stub_done <= 1'b0;
      stub_cnt  <= 0;
      stub_out  <= '0;
    end else begin
      stub_done <= 1'b0;
      if (core_ld) begin
        stub_busy <= 1'b1;
        stub_cnt  <= 3;
        stub_out  <= cipher(core_text_in, core_key);
      end else if (stub_busy) begin
        if (stub_cnt <= 1) begin
          stub_busy <= 1'b0;
          stub_done <= !stub_hang;
        end else begin
          stub_cnt <= stub_cnt - 1;
        end
      end
    end
  end

  assign core_done     = stub_done | spur_done;
  assign core_text_out = spur_done ? JUNK : stub_out;

  always @(negedge clk) begin
    if (core_ld) ld_cycles++;
    if (in_ready && (out_valid || stub_busy)) viol++;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time exceeded");
    $fatal(1);
  end

  task automatic load_key(input logic [127:0] k);
    @(negedge clk);
    key_in = k;
    key_we = 1'b1;
    @(negedge clk);
    key_we = 1'b0;
  endtask

  task automatic push_word(input logic [31:0] w, input int gap);
    int t;
    repeat (gap) @(negedge clk);
    in_data  = w;
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL push_ready: in_ready=%b required 1", in_ready);
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] p, input int gap);
    for (int i = 0; i < 4; i++) push_word(32'(p >> (96 - 32 * i)), gap);
  endtask

  task automatic recv_block(input logic [127:0] exp, input int stall);
    logic [31:0] ew;
    logic [31:0] held;
    int t;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      t = 0;
      while (!out_valid && t < 200) begin
        @(negedge clk);
        t++;
      end
      n_cmp++;
      if (out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL recv_valid w%0d: out_valid=%b required 1", i, out_valid);
      end
      if (i == 0 && stall > 0) begin
        held = out_data;
        repeat (stall) begin
          @(negedge clk);
          n_cmp++;
          if (out_data !== held || out_valid !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL stall_hold: data=%h valid=%b rdy=%b required %h 1 0",
                     out_data, out_valid, in_ready, held);
          end
        end
      end
      ew = 32'(exp >> (96 - 32 * i));
      n_cmp++;
      if (out_data !== ew) begin
        n_bad++;
        $display("FAIL out_word w%0d: got %h required %h", i, out_data, ew);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1 out_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || core_ld !== 1'b0 ||
        busy !== 1'b0 || err !== 1'b0 || key_rej !== 1'b0 ||
        blk_cnt !== 2'd0 || core_key !== '0 || core_text_in !== '0 ||
        out_data !== '0) begin
      n_bad++;
      $display("FAIL reset_state: rdy=%b ov=%b ld=%b busy=%b err=%b cnt=%0d required all 0",
               in_ready, out_valid, core_ld, busy, err, blk_cnt);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_release_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_fips;
    int ld0;
    load_key(FIPS_K);
    n_cmp++;
    if (core_key !== FIPS_K) begin
      n_bad++;
      $display("FAIL fips_key: got %h required %h", core_key, FIPS_K);
    end
    ld0 = ld_cycles;
    send_block(FIPS_P, 0);
    n_cmp++;
    if (core_text_in !== FIPS_P) begin
      n_bad++;
      $display("FAIL fips_text_in: got %h required %h", core_text_in, FIPS_P);
    end
    recv_block(FIPS_C, 0);
    n_cmp++;
    if (blk_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL fips_blk_cnt: got %0d required 1", blk_cnt);
    end
    n_cmp++;
    if (ld_cycles - ld0 != 1) begin
      n_bad++;
      $display("FAIL fips_ld_width: got %0d cycles required 1", ld_cycles - ld0);
    end
  endtask

  task automatic test_gaps_backpressure;
    viol = 0;
    send_block(FIPS_P, 1);
    recv_block(FIPS_C, 10);
    n_cmp++;
    if (blk_cnt !== 2'd2) begin
      n_bad++;
      $display("FAIL gap_blk_cnt: got %0d required 2", blk_cnt);
    end
    n_cmp++;
    if (viol != 0) begin
      n_bad++;
      $display("FAIL gap_ready_busy: got %0d cycles required 0", viol);
    end
  endtask

  task automatic test_key_reject;
    send_block(FIPS_P, 0);
    @(negedge clk);
    @(negedge clk);
    key_in = K2;
    key_we = 1'b1;
    @(posedge clk);
    #1 key_we = 1'b0;
    n_cmp++;
    if (key_rej !== 1'b1 || core_key !== FIPS_K) begin
      n_bad++;
      $display("FAIL key_rej_pulse: rej=%b key=%h required 1 %h",
               key_rej, core_key, FIPS_K);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (key_rej !== 1'b0) begin
      n_bad++;
      $display("FAIL key_rej_width: got %b required 0", key_rej);
    end
    recv_block(FIPS_C, 0);
    n_cmp++;
    if (blk_cnt !== 2'd3) begin
      n_bad++;
      $display("FAIL keyrej_blk_cnt: got %0d required 3", blk_cnt);
    end
    load_key(K2);
    n_cmp++;
    if (core_key !== K2 || key_rej !== 1'b0) begin
      n_bad++;
      $display("FAIL key_idle_load: key=%h rej=%b required %h 0", core_key, key_rej, K2);
    end
    send_block(P2, 0);
    recv_block(C2, 0);
    n_cmp++;
    if (blk_cnt !== 2'd0) begin
      n_bad++;
      $display("FAIL newkey_blk_cnt: got %0d required 0", blk_cnt);
    end
  endtask

  task automatic test_timeout;
    int n;
    stub_hang = 1'b1;
    send_block(P2, 0);
    n = 0;
    while (!err && n < 40) begin
      @(posedge clk);
      #1 n++;
    end
    stub_hang = 1'b0;
    n_cmp++;
    if (err !== 1'b1 || n < 31 || n > 32) begin
      n_bad++;
      $display("FAIL timeout_err: err=%b after %0d cycles required 1 within 31..32", err, n);
    end
    n_cmp++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || blk_cnt !== 2'd0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout_abort: rdy=%b busy=%b cnt=%0d ov=%b required 1 0 0 0",
               in_ready, busy, blk_cnt, out_valid);
    end
    send_block(P2, 0);
    recv_block(C2, 0);
    n_cmp++;
    if (err !== 1'b1 || blk_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL timeout_recover: err=%b cnt=%0d required 1 1", err, blk_cnt);
    end
  endtask

  task automatic test_reset_mid;
    int t;
    push_word(32'h00112233, 0);
    push_word(32'h44556677, 0);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0 || busy !== 1'b0 || err !== 1'b0 ||
        blk_cnt !== 2'd0 || core_text_in !== '0 || core_key !== '0) begin
      n_bad++;
      $display("FAIL rst_collect: rdy=%b busy=%b err=%b cnt=%0d required all 0",
               in_ready, busy, err, blk_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    load_key(FIPS_K);
    send_block(FIPS_P, 0);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || out_data !== '0 || blk_cnt !== 2'd0 ||
        core_ld !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_drain: ov=%b data=%h cnt=%0d ld=%b busy=%b required all 0",
               out_valid, out_data, blk_cnt, core_ld, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    load_key(FIPS_K);
    send_block(FIPS_P, 0);
    recv_block(FIPS_C, 0);
    n_cmp++;
    if (blk_cnt !== 2'd1) begin
      n_bad++;
      $display("FAIL rst_fresh_cnt: got %0d required 1", blk_cnt);
    end
  endtask

  task automatic test_wrap;
    logic [1:0] exp_cnt;
    int t;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int b = 0; b < 5; b++) begin
      exp_cnt = 2'(b + 1);
      load_key((b % 2 == 1) ? K2 : FIPS_K);
      send_block((b % 2 == 1) ? P2 : FIPS_P, 0);
      t = 0;
      while (!out_valid && t < 100) begin
        @(negedge clk);
        t++;
      end
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      recv_block((b % 2 == 1) ? C2 : FIPS_C, 0);
      n_cmp++;
      if (blk_cnt !== exp_cnt) begin
        n_bad++;
        $display("FAIL wrap_cnt b%0d: got %0d required %0d", b, blk_cnt, exp_cnt);
      end
      @(negedge clk);
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1) begin
        n_bad++;
        $display("FAIL spur_collect b%0d: ov=%b busy=%b rdy=%b required 0 0 1",
                 b, out_valid, busy, in_ready);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fips();
    test_gaps_backpressure();
    test_key_reject();
    test_timeout();
    test_reset_mid();
    test_wrap();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
